demux4_bus_router: RTL and testbench

//  Registered 1-to-4 bus distributor, the write-direction counterpart of the 4:1 address/data select mux.

---
 rtl/demux4_bus_router_pkg.sv | 16 +
 rtl/demux4_bus_router_hold_timer.sv | 38 +++
 rtl/demux4_bus_router.sv | 107 ++++++++++
 tb/tb_demux4_bus_router.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/demux4_bus_router_pkg.sv
// Shared constants, state encoding and select decode for the 1-to-4 bus router.
package demux4_bus_router_pkg;

   localparam int ADDRESS_BUS_WIDTH = 16;
   localparam int DATA_BUS_WIDTH    = 32;

   typedef enum logic {
      DEMUX_IDLE = 1'b0,
      DEMUX_HOLD = 1'b1
   } demux_state_e;

   function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
      return 4'b0001 << sel;
   endfunction

endpackage

// File: rtl/demux4_bus_router_hold_timer.sv
// Hold-cycle counter for demux4_bus_router: clears on load, counts unaccepted HOLD
// cycles and flags the cycle in which the LIMIT-th unaccepted cycle is reached.
module demux_hold_timer #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expire
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (count_en && (cnt_q != CW'(LIMIT))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A wait cycle with the counter already at LIMIT-1 is the LIMIT-th one.
   assign expire = count_en && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/demux4_bus_router.sv
// Registered 1-to-4 bus distributor with a one-entry holding register.
// Optional hold timeout is enabled by defining DEMUX_TIMEOUT_EN.
module demux4_bus_router
   import demux4_bus_router_pkg::*;
#(
   parameter int WIDTH          = ADDRESS_BUS_WIDTH,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_select,
   input  logic [WIDTH-1:0] in_data,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             timeout_err
);

   // Handshake rule: a transfer happens on a rising edge where valid and ready are
   // both high; ready may depend combinationally on the partner's ready, never on valid.

   demux_state_e     state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [1:0]       sel_q, sel_d;
   logic             accept;
   logic             load;
   logic             drop;

   assign accept = (state_q == DEMUX_HOLD) && out_ready[sel_q];
   assign load   = in_valid && in_ready;

`ifdef DEMUX_TIMEOUT_EN
   logic expire;
   logic timeout_err_q;

   demux_hold_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_hold_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (load),
      .count_en ((state_q == DEMUX_HOLD) && !accept),
      .expire   (expire)
   );

   assign drop = expire;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timeout_err_q <= 1'b0;
      end else begin
         timeout_err_q <= drop;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = |TIMEOUT_CYCLES;
   assign drop        = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      sel_d    = sel_q;
      in_ready = 1'b0;
      case (state_q)
         DEMUX_IDLE: begin
            in_ready = 1'b1;
         end
         DEMUX_HOLD: begin
            // Refill in the same cycle the destination drains the register.
            in_ready = accept;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
      if (load) begin
         state_d = DEMUX_HOLD;
         data_d  = in_data;
         sel_d   = in_select;
      end else if (accept || drop) begin
         state_d = DEMUX_IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= DEMUX_IDLE;
         data_q  <= '0;
         sel_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
      end
   end

   assign out_valid = (state_q == DEMUX_HOLD) ? sel_onehot(sel_q) : 4'b0000;
   assign out_data  = data_q;

endmodule

// File: tb/tb_demux4_bus_router.sv
// Directed self-checking bench for demux4_bus_router (default width, timeout limit 4).
module tb_demux4_bus_router;

   localparam int W = 16;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   in_select;
   logic [W-1:0] in_data;
   logic [3:0]   out_valid;
   logic [3:0]   out_ready;
   logic [W-1:0] out_data;
   logic         timeout_err;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] exp_q[$];

   demux4_bus_router #(
      .WIDTH          (W),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_select   (in_select),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .timeout_err (timeout_err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                        input logic [3:0] rdy);
      in_valid  = v;
      in_select = s;
      in_data   = d;
      out_ready = rdy;
   endtask

   logic [1:0] st_sel [4] = '{2'd0, 2'd3, 2'd1, 2'd2};
   logic [3:0] st_hot [4] = '{4'b0001, 4'b1000, 4'b0010, 4'b0100};

   initial begin
      reset = 1'b1;
      drive(1'b0, 2'd0, '0, 4'b0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 4'b0000);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_timeout_err", timeout_err, 0);
      reset = 1'b0;

      // async reset in the middle of a HOLD
      step();
      drive(1'b1, 2'd1, 16'h1234, 4'b0000);
      check("pre_rst_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("pre_rst_hold", out_valid, 4'b0010);
      #2 reset = 1'b1;
      #1;
      check("async_rst_out_valid", out_valid, 4'b0000);
      check("async_rst_out_data", out_data, 0);
      check("async_rst_in_ready", in_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      step();
      check("post_rst_no_valid", out_valid, 4'b0000);

      // single route
      drive(1'b1, 2'd2, 16'h00A5, 4'b0100);
      step();
      in_valid = 1'b0;
      check("single_out_valid", out_valid, 4'b0100);
      check("single_out_data", out_data, 16'h00A5);
      check("single_in_ready", in_ready, 1);
      step();
      check("single_idle", out_valid, 4'b0000);

      // backpressure
      drive(1'b1, 2'd1, 16'h5A5A, 4'b0000);
      step();
      drive(1'b0, 2'd3, 16'hFFFF, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", out_valid, 4'b0010);
         check("bp_out_data", out_data, 16'h5A5A);
         check("bp_in_ready", in_ready, 0);
         step();
      end
      out_ready = 4'b0010;
      #1;
      check("bp_release_in_ready", in_ready, 1);
      check("bp_release_valid", out_valid, 4'b0010);
      step();
      out_ready = 4'b0000;
      check("bp_done", out_valid, 4'b0000);

      // streaming 0,3,1,2 with data 1..4
      out_ready = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         in_valid  = 1'b1;
         in_select = st_sel[i];
         in_data   = W'(i + 1);
         exp_q.push_back(W'(i + 1));
         check("stream_in_ready", in_ready, 1);
         step();
         if (i == 3) in_valid = 1'b0;
         check("stream_onehot", out_valid, st_hot[i]);
         check("stream_data", out_data, exp_q.pop_front());
      end
      step();
      check("stream_empty", out_valid, 4'b0000);
      check("stream_queue", exp_q.size(), 0);

      // ready on the wrong ports only
      drive(1'b1, 2'd3, 16'hC3C3, 4'b0111);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("wrong_rdy_valid", out_valid, 4'b1000);
         check("wrong_rdy_data", out_data, 16'hC3C3);
         check("wrong_rdy_in_ready", in_ready, 0);
         step();
      end
      out_ready = 4'b1000;
      #1;
      check("wrong_rdy_accept", in_ready, 1);
      step();
      out_ready = 4'b0000;
      check("wrong_rdy_done", out_valid, 4'b0000);

      // hold with no destination ready
      drive(1'b1, 2'd0, 16'h0F0F, 4'b0000);
      step();
      in_valid = 1'b0;
`ifdef DEMUX_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         check("to_hold_valid", out_valid, 4'b0001);
         check("to_hold_err", timeout_err, 0);
         step();
      end
      check("to_drop_valid", out_valid, 4'b0000);
      check("to_drop_err", timeout_err, 1);
      step();
      check("to_err_pulse", timeout_err, 0);
      check("to_idle_valid", out_valid, 4'b0000);
`else
      for (int i = 0; i < 10; i++) begin
         check("hold_valid", out_valid, 4'b0001);
         check("hold_data", out_data, 16'h0F0F);
         check("hold_err", timeout_err, 0);
         step();
      end
      out_ready = 4'b0001;
      step();
      out_ready = 4'b0000;
      check("hold_drained", out_valid, 4'b0000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
